// File: rtl/keccak_round_controller_if.sv
// keccak_round_controller_if: request, round-step and completion signals between SHAKE control and the permutation sequencer
interface keccak_round_controller_if;
  logic       start_valid;
  logic       start_ready;
  logic       load_en;
  logic       round_en;
  logic [4:0] round_num;
  logic       last_round;
  logic       stall;
  logic       abort;
  logic       done_valid;
  logic       done_ready;
  logic       busy;
  modport master (
    output start_valid, stall, abort, done_ready,
    input  start_ready, load_en, round_en, round_num, last_round, done_valid, busy
  );
  modport slave (
    input  start_valid, stall, abort, done_ready,
    output start_ready, load_en, round_en, round_num, last_round, done_valid, busy
  );
endinterface

// File: rtl/keccak_round_controller.sv
// keccak_round_controller: steps the Keccak-f[1600] round index from request acceptance through completion handshake
module keccak_round_controller #(
  parameter int NUM_ROUNDS       = 24,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  keccak_round_controller_if.slave bus
);
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [4:0] round_q, round_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end
  // abort wins over everything; the unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (bus.abort) begin
      state_d = IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_valid) begin
          state_d = ROUND;
          round_d = '0;
        end
        ROUND: if (!bus.stall) begin
          state_d = (round_q == LAST) ? DONE : ROUND;
          round_d = (round_q == LAST) ? 5'd0 : round_q + STEP;
        end
        DONE: state_d = bus.done_ready ? IDLE : DONE;
        default: begin
          state_d = IDLE;
          round_d = '0;
        end
      endcase
    end
  end
  always_comb begin
    bus.start_ready = (state_q == IDLE) && !bus.abort;
    bus.load_en     = bus.start_ready && bus.start_valid;
    bus.round_en    = (state_q == ROUND) && !bus.stall && !bus.abort;
    bus.last_round  = bus.round_en && (round_q == LAST);
    bus.done_valid  = state_q == DONE;
    bus.busy        = state_q != IDLE;
    bus.round_num   = round_q;
  end
endmodule

// File: tb/tb_keccak_round_controller.sv
// tb_keccak_round_controller: directed table and sequence checks for the round controller
module tb_keccak_round_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  keccak_round_controller_if a_if ();
  keccak_round_controller_if b_if ();
  keccak_round_controller dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  keccak_round_controller #(.NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic sv, st, ab, dr;
    logic sr, le, re;
    logic [4:0] rn;
    logic lr, dv, bs;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic drive(input logic sv, input logic st, input logic ab, input logic dr);
    a_if.start_valid = sv;
    a_if.stall       = st;
    a_if.abort       = ab;
    a_if.done_ready  = dr;
    #1;
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk_rst(input string t);
    chk({t, "_start_ready"}, int'(a_if.start_ready), 1);
    chk({t, "_load_en"}, int'(a_if.load_en), 0);
    chk({t, "_round_en"}, int'(a_if.round_en), 0);
    chk({t, "_last_round"}, int'(a_if.last_round), 0);
    chk({t, "_done_valid"}, int'(a_if.done_valid), 0);
    chk({t, "_busy"}, int'(a_if.busy), 0);
    chk({t, "_round_num"}, int'(a_if.round_num), 0);
  endtask
  task automatic perm(input int stall_at, input int nstall, input int hold, input int exp_done, input string t);
    int   rn = 0;
    int   cyc;
    int   left = nstall;
    logic s;
    drive(1, 0, 0, 0);
    chk({t, "_acc_load_en"}, int'(a_if.load_en), 1);
    chk({t, "_acc_start_ready"}, int'(a_if.start_ready), 1);
    chk({t, "_acc_busy"}, int'(a_if.busy), 0);
    tick();
    cyc = 1;
    while (rn < 24) begin
      s = (rn == stall_at) && (left > 0);
      drive(0, s, 0, 1);
      chk($sformatf("%s_c%0d_round_num", t, cyc), int'(a_if.round_num), rn);
      chk($sformatf("%s_c%0d_round_en", t, cyc), int'(a_if.round_en), int'(!s));
      chk($sformatf("%s_c%0d_last_round", t, cyc), int'(a_if.last_round), int'(!s && rn == 23));
      chk($sformatf("%s_c%0d_done_valid", t, cyc), int'(a_if.done_valid), 0);
      chk($sformatf("%s_c%0d_busy", t, cyc), int'(a_if.busy), 1);
      tick();
      cyc++;
      if (s) left--;
      else rn++;
    end
    chk({t, "_done_cycle"}, cyc, exp_done);
    for (int i = 0; i <= hold; i++) begin
      drive(1, 0, 0, i == hold);
      chk($sformatf("%s_d%0d_done_valid", t, i), int'(a_if.done_valid), 1);
      chk($sformatf("%s_d%0d_start_ready", t, i), int'(a_if.start_ready), 0);
      chk($sformatf("%s_d%0d_load_en", t, i), int'(a_if.load_en), 0);
      chk($sformatf("%s_d%0d_busy", t, i), int'(a_if.busy), 1);
      tick();
    end
    drive(0, 0, 0, 0);
    chk({t, "_end_busy"}, int'(a_if.busy), 0);
    chk({t, "_end_start_ready"}, int'(a_if.start_ready), 1);
    chk({t, "_end_done_valid"}, int'(a_if.done_valid), 0);
    chk({t, "_end_round_num"}, int'(a_if.round_num), 0);
  endtask
  initial begin
    int acc [$];
    //             sv st ab dr   sr le re  rn  lr dv bs
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    b_if.start_valid = 1'b0;
    b_if.stall = 1'b0;
    b_if.abort = 1'b0;
    b_if.done_ready = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk_rst("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      b_if.start_valid = tbl[i].sv;
      b_if.stall       = tbl[i].st;
      b_if.abort       = tbl[i].ab;
      b_if.done_ready  = tbl[i].dr;
      #1;
      chk($sformatf("v%0d_start_ready", i), int'(b_if.start_ready), int'(tbl[i].sr));
      chk($sformatf("v%0d_load_en", i), int'(b_if.load_en), int'(tbl[i].le));
      chk($sformatf("v%0d_round_en", i), int'(b_if.round_en), int'(tbl[i].re));
      chk($sformatf("v%0d_round_num", i), int'(b_if.round_num), int'(tbl[i].rn));
      chk($sformatf("v%0d_last_round", i), int'(b_if.last_round), int'(tbl[i].lr));
      chk($sformatf("v%0d_done_valid", i), int'(b_if.done_valid), int'(tbl[i].dv));
      chk($sformatf("v%0d_busy", i), int'(b_if.busy), int'(tbl[i].bs));
      tick();
    end
    b_if.start_valid = 1'b0;
    perm(99, 0, 0, 25, "default");
    tick();
    perm(5, 3, 4, 28, "stall");
    tick();
    drive(1, 0, 0, 0);
    tick();
    repeat (10) begin
      drive(0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    chk("abort_r_round_num", int'(a_if.round_num), 10);
    chk("abort_r_round_en", int'(a_if.round_en), 0);
    chk("abort_r_start_ready", int'(a_if.start_ready), 0);
    tick();
    drive(0, 0, 0, 1);
    chk("abort_r_next_busy", int'(a_if.busy), 0);
    chk("abort_r_next_round_num", int'(a_if.round_num), 0);
    chk("abort_r_next_start_ready", int'(a_if.start_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_r_no_done%0d", i), int'(a_if.done_valid), 0);
    end
    drive(1, 0, 0, 0);
    tick();
    repeat (24) begin
      drive(0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    chk("abort_d_done_valid", int'(a_if.done_valid), 1);
    chk("abort_d_start_ready", int'(a_if.start_ready), 0);
    tick();
    drive(0, 0, 0, 0);
    chk("abort_d_next_busy", int'(a_if.busy), 0);
    chk("abort_d_next_done_valid", int'(a_if.done_valid), 0);
    chk("abort_d_next_start_ready", int'(a_if.start_ready), 1);
    drive(1, 0, 0, 0);
    tick();
    repeat (17) begin
      drive(0, 0, 0, 0);
      tick();
    end
    chk("arst_pre_round_num", int'(a_if.round_num), 17);
    #2 rst_n = 1'b0;
    #1 chk_rst("arst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    perm(99, 0, 0, 25, "post_rst");
    tick();
    drive(1, 0, 0, 1);
    for (int c = 0; c < 60; c++) begin
      if (a_if.load_en) acc.push_back(c);
      tick();
      #1;
    end
    chk("b2b_accepts", acc.size(), 3);
    for (int i = 1; i < acc.size(); i++) chk($sformatf("b2b_gap%0d", i), acc[i] - acc[i-1], 26);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("b2b_end_busy", int'(a_if.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
